// File: rtl/spi_pkg.sv
// Shared SPI frame definitions for the 4-command master/slave protocol.
package spi_pkg;

    localparam int FRAME_W = 11;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SHIFT,
        ST_WAIT,
        ST_RECV,
        ST_GAP
    } state_t;

    // Leading bit duplicates cmd[1] so the slave can pick its write/read path first.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0]        cmd,
                                                      input logic [DATA_W-1:0] data);
        return {cmd[1], cmd, data};
    endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Frame shift-out register, response shift-in register and shared bit counter.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [FRAME_W-1:0] frame,
    input  logic              shift_en,
    input  logic              sample_en,
    input  logic              miso,
    input  logic              cnt_load,
    input  logic [3:0]        cnt_init,
    input  logic              cnt_dec,
    output logic              tx_bit,
    output logic [DATA_W-1:0] rx_next,
    output logic [3:0]        bit_cnt
);

    logic [FRAME_W-1:0] tx_sr;
    logic [DATA_W-1:0]  rx_sr;

    assign tx_bit  = tx_sr[FRAME_W-1];
    assign rx_next = {rx_sr[DATA_W-2:0], miso};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else begin
            if (load)
                tx_sr <= frame;
            else if (shift_en)
                tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};

            if (sample_en)
                rx_sr <= rx_next;

            if (cnt_load)
                bit_cnt <= cnt_init;
            else if (cnt_dec && bit_cnt != 4'd0)
                bit_cnt <= bit_cnt - 4'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master: turns command handshakes into SS_n/MOSI frames and returns RD_DATA bytes.
// state  | meaning
// IDLE   | SS_n high, cmd_ready high, waiting for a command
// SELECT | SS_n low one cycle before the first frame bit
// SHIFT  | 11 frame bits on MOSI, MSB first
// WAIT   | RD_DATA turnaround before MISO sampling
// RECV   | 8 MISO bits shifted in, MSB first
// GAP    | SS_n high for GAP cycles before returning to IDLE
module spi_master
    import spi_pkg::*;
#(
    parameter int TURNAROUND = 1,
    parameter int GAP        = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);
    localparam logic [7:0] TA_LOAD  = 8'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    state_t            state, next_state;
    logic              is_rd;
    logic [7:0]        tmr, tmr_init;
    logic              tmr_load;
    logic              cnt_load;
    logic [3:0]        cnt_init;
    logic [3:0]        bit_cnt;
    logic              tx_bit;
    logic [DATA_W-1:0] rx_next;
    logic              accept;
    logic              rsp_fire;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_ready && cmd_valid;
    // Last MISO sample lands one edge before RECV exits, with bit_cnt at 1.
    assign rsp_fire  = (state == ST_RECV) && (bit_cnt == 4'd1);

    spi_master_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .frame     (make_frame(cmd_type, cmd_data)),
        .shift_en  (next_state == ST_SHIFT),
        .sample_en (next_state == ST_RECV),
        .miso      (MISO),
        .cnt_load  (cnt_load),
        .cnt_init  (cnt_init),
        .cnt_dec   (state == ST_SHIFT || state == ST_RECV),
        .tx_bit    (tx_bit),
        .rx_next   (rx_next),
        .bit_cnt   (bit_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_init   = '0;
        cnt_load   = 1'b0;
        cnt_init   = '0;
        case (state)
            ST_IDLE:
                if (cmd_valid) next_state = ST_SELECT;
            ST_SELECT: begin
                next_state = ST_SHIFT;
                cnt_load   = 1'b1;
                cnt_init   = 4'(FRAME_W - 1);
            end
            ST_SHIFT:
                if (bit_cnt == 4'd0) begin
                    if (!is_rd) begin
                        next_state = ST_GAP;
                        tmr_load   = 1'b1;
                        tmr_init   = GAP_LOAD;
                    end else if (TURNAROUND == 0) begin
                        next_state = ST_RECV;
                        cnt_load   = 1'b1;
                        cnt_init   = 4'(DATA_W - 1);
                    end else begin
                        next_state = ST_WAIT;
                        tmr_load   = 1'b1;
                        tmr_init   = TA_LOAD;
                    end
                end
            ST_WAIT:
                if (tmr == 8'd0) begin
                    next_state = ST_RECV;
                    cnt_load   = 1'b1;
                    cnt_init   = 4'(DATA_W - 1);
                end
            ST_RECV:
                if (bit_cnt == 4'd0) begin
                    next_state = ST_GAP;
                    tmr_load   = 1'b1;
                    tmr_init   = GAP_LOAD;
                end
            ST_GAP:
                if (tmr == 8'd0) next_state = ST_IDLE;
            default:
                next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_rd     <= 1'b0;
            tmr       <= '0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (accept)
                is_rd <= (cmd_type == CMD_RD_DATA);
            if (tmr_load)
                tmr <= tmr_init;
            else if (tmr != 8'd0)
                tmr <= tmr - 8'd1;
            SS_n      <= (next_state == ST_IDLE) || (next_state == ST_GAP);
            MOSI      <= (next_state == ST_SHIFT) && tx_bit;
            busy      <= (next_state != ST_IDLE);
            rsp_valid <= rsp_fire;
            if (rsp_fire)
                rsp_data <= rx_next;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master against a cycle-count frame model and a slave RAM model.
module tb_spi_master;

    localparam int GAP = 2;
    localparam int TA_OF [3] = '{1, 0, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid [3];
    logic       cmd_ready [3];
    logic [1:0] cmd_type  [3];
    logic [7:0] cmd_data  [3];
    logic       rsp_valid [3];
    logic [7:0] rsp_data  [3];
    logic       busy      [3];
    logic       ss_n      [3];
    logic       mosi      [3];
    logic       miso      [3];

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] ram [256];
    logic [7:0] cur_addr;
    logic [7:0] last_rsp [3];

    always #5 clk = ~clk;

    spi_master #(.TURNAROUND(1), .GAP(GAP)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_type(cmd_type[0]), .cmd_data(cmd_data[0]), .rsp_valid(rsp_valid[0]),
        .rsp_data(rsp_data[0]), .busy(busy[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0]));
    spi_master #(.TURNAROUND(0), .GAP(GAP)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_type(cmd_type[1]), .cmd_data(cmd_data[1]), .rsp_valid(rsp_valid[1]),
        .rsp_data(rsp_data[1]), .busy(busy[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1]));
    spi_master #(.TURNAROUND(3), .GAP(GAP)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_type(cmd_type[2]), .cmd_data(cmd_data[2]), .rsp_valid(rsp_valid[2]),
        .rsp_data(rsp_data[2]), .busy(busy[2]), .SS_n(ss_n[2]), .MOSI(mosi[2]), .MISO(miso[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_len(input logic [1:0] typ, input int ta);
        return (typ == 2'b11) ? 20 + ta : 12;
    endfunction

    // Slave RAM behaviour: addresses and writes take effect when the frame completes.
    task automatic model_update(input logic [1:0] typ, input logic [7:0] data);
        case (typ)
            2'b00, 2'b10: cur_addr = data;
            2'b01:        ram[cur_addr] = data;
            default:      ;
        endcase
    endtask

    task automatic run_cmd(input int d, input logic [1:0] typ, input logic [7:0] data,
                           input bit ovr, input logic [7:0] ovr_byte);
        int          ta, len, k, wait_cyc;
        int          ss_low, busy_hi, rdy_lo, rsp_cnt, rsp_at, mosi_extra;
        logic [10:0] got_frame, exp_frame;
        logic [7:0]  miso_byte;
        ta        = TA_OF[d];
        len       = frame_len(typ, ta);
        exp_frame = {typ[1], typ, data};
        miso_byte = ovr ? ovr_byte : ram[cur_addr];
        cmd_type[d]  = typ;
        cmd_data[d]  = data;
        cmd_valid[d] = 1'b1;
        wait_cyc = 0;
        while (!cmd_ready[d] && wait_cyc < 100) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        chk("accept_ready", 32'(cmd_ready[d]), 32'd1);
        @(posedge clk); #1;
        cmd_valid[d] = 1'b0;
        cmd_type[d]  = 2'($urandom);
        cmd_data[d]  = 8'($urandom);
        got_frame = '0;
        ss_low = 0; busy_hi = 0; rdy_lo = 0; rsp_cnt = 0; rsp_at = -1; mosi_extra = 0;
        for (int n = 0; n <= len + GAP; n++) begin
            if (!ss_n[d])     ss_low++;
            if (busy[d])      busy_hi++;
            if (!cmd_ready[d]) rdy_lo++;
            if (n >= 1 && n <= 11) got_frame = {got_frame[9:0], mosi[d]};
            else if (mosi[d])      mosi_extra++;
            if (rsp_valid[d]) begin
                rsp_cnt++;
                rsp_at = n;
            end
            // Bit k must be stable at edge T+12+ta+k, so present it one cycle earlier.
            k = n - 11 - ta;
            if (k >= 0 && k <= 7) miso[d] = miso_byte[7-k];
            else                  miso[d] = 1'($urandom);
            if (n < len + GAP) begin
                @(posedge clk); #1;
            end
        end
        chk("mosi_frame", 32'(got_frame), 32'(exp_frame));
        chk("mosi_idle_zero", 32'(mosi_extra), 32'd0);
        chk("ss_low_cycles", 32'(ss_low), 32'(len));
        chk("busy_cycles", 32'(busy_hi), 32'(len + GAP));
        chk("ready_low_cycles", 32'(rdy_lo), 32'(len + GAP));
        if (typ == 2'b11) begin
            chk("rsp_pulses", 32'(rsp_cnt), 32'd1);
            chk("rsp_time", 32'(rsp_at), 32'(19 + ta));
            chk("rsp_data", 32'(rsp_data[d]), 32'(miso_byte));
            last_rsp[d] = miso_byte;
        end else begin
            chk("no_rsp", 32'(rsp_cnt), 32'd0);
            chk("rsp_hold", 32'(rsp_data[d]), 32'(last_rsp[d]));
        end
        if (d == 0) model_update(typ, data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] qt [4];
        logic [7:0] qd [4];
        int         acc_t [4];
        int         acc, cyc, ss_hi_between;
        logic       rdy;

        for (int i = 0; i < 3; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_type[i]  = 2'b00;
            cmd_data[i]  = 8'h00;
            miso[i]      = 1'b0;
            last_rsp[i]  = 8'h00;
        end
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        cur_addr = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss_n", 32'(ss_n[0]), 32'd1);
        chk("rst_mosi", 32'(mosi[0]), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data[0]), 32'h00);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready[0]), 32'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        run_cmd(0, 2'b00, 8'hD7, 1'b0, 8'h00);
        run_cmd(0, 2'b01, 8'hD3, 1'b0, 8'h00);
        run_cmd(0, 2'b10, 8'hD7, 1'b0, 8'h00);
        run_cmd(0, 2'b11, 8'hD5, 1'b0, 8'h00);
        chk("ram_readback", 32'(rsp_data[0]), 32'hD3);

        run_cmd(1, 2'b11, 8'h3C, 1'b1, 8'hA5);
        run_cmd(2, 2'b11, 8'h3C, 1'b1, 8'hA5);
        chk("a5_ta0", 32'(rsp_data[1]), 32'hA5);
        chk("a5_ta3", 32'(rsp_data[2]), 32'hA5);

        // Four commands queued behind a held cmd_valid.
        qt = '{2'b00, 2'b11, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) qd[i] = 8'($urandom);
        acc = 0; cyc = 0; ss_hi_between = 0;
        cmd_valid[0] = 1'b1;
        for (int c = 0; c < 300 && acc < 4; c++) begin
            cmd_type[0] = qt[acc];
            cmd_data[0] = qd[acc];
            rdy = cmd_ready[0];
            @(posedge clk); #1;
            cyc++;
            if (rdy) begin
                acc_t[acc] = cyc;
                model_update(qt[acc], qd[acc]);
                acc++;
            end
            if (acc == 1 && ss_n[0]) ss_hi_between++;
            miso[0] = 1'($urandom);
        end
        cmd_valid[0] = 1'b0;
        chk("queued_accepts", 32'(acc), 32'd4);
        for (int i = 1; i < acc; i++)
            chk("queued_spacing", 32'(acc_t[i] - acc_t[i-1]),
                32'(frame_len(qt[i-1], TA_OF[0]) + GAP + 1));
        chk("ss_high_between", 32'(ss_hi_between), 32'(GAP + 1));
        repeat (30) @(posedge clk);
        #1;
        if (rsp_valid[0] == 1'b0) last_rsp[0] = rsp_data[0];

        // Reset in the middle of an RD_DATA frame.
        cmd_type[0]  = 2'b11;
        cmd_data[0]  = 8'h5A;
        cmd_valid[0] = 1'b1;
        for (int w = 0; w < 100 && !cmd_ready[0]; w++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ss_n", 32'(ss_n[0]), 32'd1);
        chk("abort_mosi", 32'(mosi[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_ready", 32'(cmd_ready[0]), 32'd1);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3; i++) last_rsp[i] = 8'h00;
        begin
            int pulses;
            pulses = 0;
            for (int c = 0; c < 30; c++) begin
                @(posedge clk); #1;
                if (rsp_valid[0]) pulses++;
            end
            chk("abort_no_rsp", 32'(pulses), 32'd0);
        end
        run_cmd(0, 2'b10, 8'hD7, 1'b0, 8'h00);
        run_cmd(0, 2'b11, 8'h00, 1'b0, 8'h00);

        for (int i = 0; i < 24; i++)
            run_cmd(0, 2'($urandom), 8'($urandom), 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            run_cmd(1, 2'b11, 8'($urandom), 1'b1, 8'($urandom));
            run_cmd(2, 2'b11, 8'($urandom), 1'b1, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
